// File: rtl/lcd_text_driver.sv
// HD44780-style 8-bit LCD text driver.
// Runs the power-up wait and init sequence, then refreshes two 16-character
// lines from a frame buffer. The buffer is snapshotted from text_in on every
// entry to the line-1 address transfer, so each frame is internally consistent.
module lcd_text_driver #(
  parameter int unsigned T_PWR = 1500000,
  parameter int unsigned T_SU  = 4,
  parameter int unsigned T_EH  = 12,
  parameter int unsigned T_W   = 4000,
  parameter int unsigned T_CLR = 164000
) (
  input  logic         Clk,
  input  logic         reset,
  input  logic [256:0] text_in,
  output logic [7:0]   lcd_db,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic         init_done,
  output logic         frame_done
);

  localparam int unsigned MAX_A   = (T_PWR > T_CLR) ? T_PWR : T_CLR;
  localparam int unsigned MAX_B   = (T_W > T_EH) ? T_W : T_EH;
  localparam int unsigned MAX_C   = (MAX_B > T_SU) ? MAX_B : T_SU;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_C) ? MAX_A : MAX_C;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned IW      = 5;

  typedef enum logic [2:0] {
    S_PWRUP  = 3'd0,
    S_INIT   = 3'd1,
    S_ADDR1  = 3'd2,
    S_CHARS1 = 3'd3,
    S_ADDR2  = 3'd4,
    S_CHARS2 = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    P_SU = 2'd0,
    P_EH = 2'd1,
    P_WT = 2'd2
  } phase_e;

  state_e          state_q, state_d;
  phase_e          phase_q, phase_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [255:0]    fbuf_q, fbuf_d;
  logic [7:0]      db_q, db_d;
  logic            rs_q, rs_d;
  logic            e_q, e_d;
  logic            init_done_q, init_done_d;
  logic            frame_done_q, frame_done_d;

  logic            wait_last;
  logic [7:0]      char_sel;

  // Bit 256 of text_in carries no information for this display.
  logic unused_text_msb;
  assign unused_text_msb = text_in[256];

  // Wait phase ends after T_CLR for the Clear command, T_W for everything else.
  always_comb begin
    if (state_q == S_INIT && idx_q == IW'(3)) begin
      wait_last = (cnt_q == CW'(T_CLR - 1));
    end else begin
      wait_last = (cnt_q == CW'(T_W - 1));
    end
  end

  // State, phase, counter and index registers.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= S_PWRUP;
      phase_q <= P_SU;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: phase sequencing within a transfer, then transfer sequencing.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    if (state_q == S_PWRUP) begin
      if (cnt_q == CW'(T_PWR - 1)) begin
        state_d = S_INIT;
        phase_d = P_SU;
        cnt_d   = '0;
        idx_d   = '0;
      end
    end else begin
      unique case (phase_q)
        P_SU: begin
          if (cnt_q == CW'(T_SU - 1)) begin
            phase_d = P_EH;
            cnt_d   = '0;
          end
        end
        P_EH: begin
          if (cnt_q == CW'(T_EH - 1)) begin
            phase_d = P_WT;
            cnt_d   = '0;
          end
        end
        P_WT: begin
          if (wait_last) begin
            phase_d = P_SU;
            cnt_d   = '0;
            unique case (state_q)
              S_INIT: begin
                if (idx_q == IW'(3)) begin
                  state_d = S_ADDR1;
                  idx_d   = '0;
                end else begin
                  idx_d = idx_q + IW'(1);
                end
              end
              S_ADDR1: begin
                state_d = S_CHARS1;
                idx_d   = '0;
              end
              S_CHARS1: begin
                if (idx_q == IW'(15)) begin
                  state_d = S_ADDR2;
                end else begin
                  idx_d = idx_q + IW'(1);
                end
              end
              S_ADDR2: begin
                state_d = S_CHARS2;
                idx_d   = IW'(16);
              end
              S_CHARS2: begin
                if (idx_q == IW'(31)) begin
                  state_d = S_ADDR1;
                  idx_d   = '0;
                end else begin
                  idx_d = idx_q + IW'(1);
                end
              end
              default: begin
                state_d = S_PWRUP;
                idx_d   = '0;
              end
            endcase
          end
        end
        default: begin
          phase_d = P_SU;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Character k lives at bits [255-8k -: 8]; ~idx equals 31-idx for a 5-bit index.
  assign char_sel = fbuf_d[{~idx_d, 3'b000} +: 8];

  // Output decode from the upcoming state so bus pins change with the transfer boundary.
  always_comb begin
    fbuf_d       = fbuf_q;
    db_d         = 8'h00;
    rs_d         = 1'b0;
    e_d          = 1'b0;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    if (state_d == S_ADDR1 && state_q != S_ADDR1) begin
      fbuf_d = text_in[255:0];
    end
    if (state_q == S_INIT && state_d == S_ADDR1) begin
      init_done_d = 1'b1;
    end
    if (state_q == S_CHARS2 && state_d == S_ADDR1) begin
      frame_done_d = 1'b1;
    end
    unique case (state_d)
      S_INIT: begin
        unique case (idx_d)
          IW'(0):  db_d = 8'h38;
          IW'(1):  db_d = 8'h0C;
          IW'(2):  db_d = 8'h06;
          default: db_d = 8'h01;
        endcase
      end
      S_ADDR1:  db_d = 8'h80;
      S_ADDR2:  db_d = 8'hC0;
      S_CHARS1,
      S_CHARS2: begin
        db_d = char_sel;
        rs_d = 1'b1;
      end
      default:  db_d = 8'h00;
    endcase
    e_d = (state_d != S_PWRUP) && (phase_d == P_EH);
  end

  // Registered LCD pins, status flags and frame snapshot.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      fbuf_q       <= '0;
      db_q         <= 8'h00;
      rs_q         <= 1'b0;
      e_q          <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      fbuf_q       <= fbuf_d;
      db_q         <= db_d;
      rs_q         <= rs_d;
      e_q          <= e_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign lcd_db     = db_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_e      = e_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;

endmodule
